// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin share of one cache-line memory port between I-cache and D-cache.
// One latched transfer runs to completion; only the granted cache sees a resp pulse.
module cacheline_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       icache_address,
    input  logic              icache_read,
    output logic [s_line-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic [31:0]       dcache_address,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [s_line-1:0] dcache_wdata,
    output logic [s_line-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);
    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              op_q, op_d;
    logic [31:0]       addr_q, addr_d;
    logic [s_line-1:0] wdata_q, wdata_d;
    logic              i_req, d_req, grant_i, grant_d;
    assign i_req   = icache_read;
    assign d_req   = dcache_read | dcache_write;
    // on a tie the requester that did not win last time goes first
    assign grant_i = i_req & (~d_req | last_grant_q);
    assign grant_d = d_req & ~grant_i;
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = 1'b0;
                    op_d         = 1'b0;
                    addr_d       = icache_address & addr_mask;
                end else if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = 1'b1;
                    op_d         = dcache_write;
                    addr_d       = dcache_address & addr_mask;
                    wdata_d      = dcache_wdata;
                end
            end
            SERVE_I, SERVE_D: state_d = pmem_resp ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end
    assign pmem_read    = (state_q != IDLE) & ~op_q;
    assign pmem_write   = (state_q != IDLE) & op_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign icache_resp  = (state_q == SERVE_I) & pmem_resp;
    assign dcache_resp  = (state_q == SERVE_D) & pmem_resp;
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed and random traffic against a transaction-level arbiter model.
// The model tracks which cache owns the port and what was latched at grant time.
module tb_cacheline_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_address, dcache_address, pmem_address;
    logic         icache_read, icache_resp, dcache_read, dcache_write, dcache_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [255:0] icache_rdata, dcache_rdata, dcache_wdata, pmem_wdata, pmem_rdata;
    int           n_vec = 0, n_err = 0;
    int           m_cur, m_gi, m_gd, n_ir, n_dr;
    logic         m_last, m_write, i_fin, d_fin;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    always #5 clk = ~clk;
    cacheline_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_address(icache_address), .icache_read(icache_read),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_address(dcache_address), .dcache_read(dcache_read),
        .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic model_reset;
        m_cur = 0; m_last = 1'b1; m_write = 1'b0; m_addr = '0; m_wdata = '0;
        i_fin = 1'b0; d_fin = 1'b0;
    endtask
    // owner: 0 = nobody, 1 = I-cache, 2 = D-cache
    task automatic model_update;
        logic ireq, dreq;
        if (!rst) return;
        ireq = icache_read;
        dreq = dcache_read || dcache_write;
        if (m_cur == 0) begin
            if (ireq && (!dreq || m_last)) begin
                m_cur = 1; m_addr = icache_address & ~32'h1f; m_write = 1'b0; m_last = 1'b0; m_gi++;
            end else if (dreq) begin
                m_cur = 2; m_addr = dcache_address & ~32'h1f; m_wdata = dcache_wdata;
                m_write = dcache_write; m_last = 1'b1; m_gd++;
            end
        end else if (pmem_resp) begin
            if (m_cur == 1) i_fin = 1'b1; else d_fin = 1'b1;
            m_cur = 0;
        end
    endtask
    task automatic check_outputs;
        chk("pmem_read", pmem_read, m_cur != 0 && !m_write);
        chk("pmem_write", pmem_write, m_cur != 0 && m_write);
        chk("pmem_address", pmem_address, m_addr);
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("icache_resp", icache_resp, m_cur == 1 && pmem_resp);
        chk("dcache_resp", dcache_resp, m_cur == 2 && pmem_resp);
        chk("icache_rdata", icache_rdata, pmem_rdata);
        chk("dcache_rdata", dcache_rdata, pmem_rdata);
        n_ir += int'(icache_resp);
        n_dr += int'(dcache_resp);
    endtask
    task automatic tick;
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask
    initial begin
        int dw;
        rst = 1'b0; icache_read = 0; dcache_read = 0; dcache_write = 0; pmem_resp = 0;
        icache_address = 0; dcache_address = 0; dcache_wdata = 0; pmem_rdata = 0;
        model_reset();
        m_gi = 0; m_gd = 0; n_ir = 0; n_dr = 0;
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            icache_read = 1'($urandom); dcache_read = 1'($urandom); dcache_write = 1'($urandom);
            icache_address = $urandom; dcache_address = $urandom;
            dcache_wdata = {8{$urandom}}; pmem_rdata = {8{$urandom}}; pmem_resp = 1'($urandom);
            tick();
        end
        rst = 1'b1; pmem_resp = 0;
        icache_read = 1; icache_address = 32'h0000_0100;
        dcache_read = 1; dcache_write = 0; dcache_address = 32'h0000_0200;
        tick();
        #1 chk("first_tie_i", {pmem_read, pmem_address}, {1'b1, 32'h0000_0100});
        pmem_resp = 1; tick();
        icache_read = 0; pmem_resp = 0; tick();
        pmem_resp = 1; tick();
        dcache_read = 0; pmem_resp = 0; tick();
        icache_read = 1; icache_address = 32'h0000_1234; tick();
        #1 chk("i_addr", pmem_address, 32'h0000_1220);
        tick(); tick(); tick();
        pmem_resp = 1; pmem_rdata = {32{8'hA5}};
        #1 chk("i_rdata", {icache_resp, icache_rdata}, {1'b1, {32{8'hA5}}});
        tick();
        icache_read = 0; pmem_resp = 0; tick();
        tick();
        chk("i_resp_once", n_ir, 2);
        dcache_write = 1; dcache_address = 32'h8000_0040; dcache_wdata = {4{64'h0123_4567_89ab_cdef}};
        tick();
        #1 chk("wb_strobe", {pmem_write, pmem_read, pmem_wdata}, {2'b10, {4{64'h0123_4567_89ab_cdef}}});
        tick();
        pmem_resp = 1; tick();
        dcache_write = 0; dcache_read = 1; dcache_address = 32'h8000_0080; pmem_resp = 0;
        #1 chk("wb_gap_idle", {pmem_write, pmem_read}, 2'b00);
        tick();
        #1 chk("fill_strobe", {pmem_read, pmem_address}, {1'b1, 32'h8000_0080});
        tick();
        pmem_resp = 1; tick();
        dcache_read = 0; pmem_resp = 0; tick();
        chk("d_resp_twice", n_dr, 3);
        dcache_read = 1; dcache_address = 32'h0000_4000; tick();
        tick();
        icache_read = 1; icache_address = 32'h0000_5000; tick();
        tick();
        pmem_resp = 1; tick();
        dcache_read = 0; pmem_resp = 0;
        #1 chk("holdoff_idle", pmem_read, 1'b0);
        tick();
        #1 chk("holdoff_i_start", {pmem_read, pmem_address}, {1'b1, 32'h0000_5000});
        pmem_resp = 1; tick();
        icache_read = 0; pmem_resp = 0; tick();
        dcache_write = 1; dcache_address = 32'h0000_6000; tick();
        tick();
        rst = 1'b0;
        model_reset();
        #1 chk("async_drop", {pmem_write, pmem_read, pmem_address}, 34'h0);
        dcache_write = 0; tick();
        rst = 1'b1; pmem_resp = 1; tick();
        pmem_resp = 0; tick();
        m_gi = 0; m_gd = 0; n_ir = 0; n_dr = 0; i_fin = 0; d_fin = 0;
        for (int c = 0; c < 3000; c++) begin
            int pct;
            pct = (c < 300) ? 100 : (c < 2800 ? 40 : 0);
            if (i_fin) icache_read = 0;
            if (d_fin) begin dcache_read = 0; dcache_write = 0; end
            i_fin = 0; d_fin = 0;
            if (!icache_read && $urandom_range(99) < pct) icache_read = 1;
            if (!dcache_read && !dcache_write && $urandom_range(99) < pct) begin
                dw = $urandom_range(2);
                dcache_read = (dw != 1); dcache_write = (dw != 0);
            end
            icache_address = $urandom; dcache_address = $urandom;
            dcache_wdata = {8{$urandom}}; pmem_rdata = {8{$urandom}};
            pmem_resp = (m_cur != 0) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            tick();
        end
        chk("i_resp_count", n_ir, m_gi);
        chk("d_resp_count", n_dr, m_gd);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
